// File: rtl/aes_pkg.sv
// Shared Rijndael state types, block-size constants and the ShiftRows row-offset table.
package aes_pkg;

    localparam int NB_AES = 4;
    localparam int NB_192 = 6;
    localparam int NB_256 = 8;
    localparam int NB_MAX = NB_256;

    typedef logic [7:0] byte_t;

    // Byte array [row][col] sized for the widest block; narrower blocks use columns 0..NB-1.
    typedef byte_t [0:3][0:NB_MAX-1] state_t;

    // The 256-bit block skips offset 2 so that rows 2 and 3 spread further apart.
    function automatic int row_offset(input int nb, input int r);
        return (nb == NB_256 && r >= 2) ? r + 1 : r;
    endfunction

endpackage

// File: rtl/rijndael_row_permute.sv
// Combinational ShiftRows / InvShiftRows byte permutation for an NB-column Rijndael state.
// Zero latency, no flow control; pure wiring plus one 2:1 mux per byte.
module rijndael_row_permute
    import aes_pkg::*;
#(
    parameter int NB = NB_AES
) (
    input  logic [32*NB-1:0] state_in,
    input  logic             inv,
    output logic [32*NB-1:0] state_out
);

    if (NB != NB_AES && NB != NB_192 && NB != NB_256) begin : g_bad_nb
        $error("rijndael_row_permute: NB must be 4, 6 or 8");
    end

    // Column c sits at bits [32*(NB-c)-1 -: 32], row 0 being the top byte of the column.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int OFF     = row_offset(NB, r);
            localparam int SRC_F   = (c + OFF) % NB;
            localparam int SRC_I   = (c - OFF + NB) % NB;
            localparam int DST_LSB = 32*(NB-c) - 8 - 8*r;
            localparam int FWD_LSB = 32*(NB-SRC_F) - 8 - 8*r;
            localparam int INV_LSB = 32*(NB-SRC_I) - 8 - 8*r;

            assign state_out[DST_LSB +: 8] = inv ? state_in[INV_LSB +: 8]
                                                 : state_in[FWD_LSB +: 8];
        end
    end

endmodule

// File: rtl/shift_rows_pipe.sv
// Two-stage valid/ready ShiftRows/InvShiftRows pipe with per-beat mode and sideband tag; latency 2.
// Backpressure: s2 holds while out_ready is low, s1 fills behind it, then in_ready drops.
module shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int NB    = NB_AES,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [32*NB-1:0] in_data,
    input  logic             in_inv,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [32*NB-1:0] out_data,
    output logic             out_inv,
    output logic [TAG_W-1:0] out_tag
);

    logic             r_s1_vld;
    logic [32*NB-1:0] r_s1_dat;
    logic             r_s1_inv;
    logic [TAG_W-1:0] r_s1_tag;

    logic             r_s2_vld;
    logic [32*NB-1:0] r_s2_dat;
    logic             r_s2_inv;
    logic [TAG_W-1:0] r_s2_tag;

    logic             w_s1_rdy;
    logic             w_s2_rdy;
    logic [32*NB-1:0] w_perm;

    assign w_s2_rdy = !r_s2_vld || out_ready;
    assign w_s1_rdy = !r_s1_vld || w_s2_rdy;
    assign in_ready = w_s1_rdy;

    // Data registers load only on a real handshake so idle X on in_data never enters the pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_dat <= '0;
            r_s1_inv <= 1'b0;
            r_s1_tag <= '0;
        end else begin
            if (w_s1_rdy) begin
                r_s1_vld <= in_valid;
            end
            if (in_valid && w_s1_rdy) begin
                r_s1_dat <= in_data;
                r_s1_inv <= in_inv;
                r_s1_tag <= in_tag;
            end
        end
    end

    rijndael_row_permute #(
        .NB (NB)
    ) u_permute (
        .state_in  (r_s1_dat),
        .inv       (r_s1_inv),
        .state_out (w_perm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld <= 1'b0;
            r_s2_dat <= '0;
            r_s2_inv <= 1'b0;
            r_s2_tag <= '0;
        end else begin
            if (w_s2_rdy) begin
                r_s2_vld <= r_s1_vld;
            end
            if (r_s1_vld && w_s2_rdy) begin
                r_s2_dat <= w_perm;
                r_s2_inv <= r_s1_inv;
                r_s2_tag <= r_s1_tag;
            end
        end
    end

    assign out_valid = r_s2_vld;
    assign out_data  = r_s2_dat;
    assign out_inv   = r_s2_inv;
    assign out_tag   = r_s2_tag;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed and randomised checks of shift_rows_pipe at NB=4, 6 and 8.
module tb_shift_rows_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;

    logic         in_valid4, in_ready4, in_inv4, out_valid4, out_ready4, out_inv4;
    logic [127:0] in_data4, out_data4;
    logic [3:0]   in_tag4, out_tag4;

    logic         in_valid6, in_ready6, in_inv6, out_valid6, out_ready6, out_inv6;
    logic [191:0] in_data6, out_data6;
    logic [3:0]   in_tag6, out_tag6;

    logic         in_valid8, in_ready8, in_inv8, out_valid8, out_ready8, out_inv8;
    logic [255:0] in_data8, out_data8;
    logic [3:0]   in_tag8, out_tag8;

    shift_rows_pipe #(.NB(4), .TAG_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_inv(in_inv4), .in_tag(in_tag4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .out_inv(out_inv4), .out_tag(out_tag4)
    );

    shift_rows_pipe #(.NB(6), .TAG_W(4)) u_dut6 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid6), .in_ready(in_ready6), .in_data(in_data6), .in_inv(in_inv6), .in_tag(in_tag6),
        .out_valid(out_valid6), .out_ready(out_ready6), .out_data(out_data6), .out_inv(out_inv6), .out_tag(out_tag6)
    );

    shift_rows_pipe #(.NB(8), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_inv(in_inv8), .in_tag(in_tag8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8), .out_inv(out_inv8), .out_tag(out_tag8)
    );

    localparam logic [127:0] A_IN  = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
    localparam logic [127:0] A_OUT = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] C_IN  = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [127:0] C_OUT = 128'h00050a0f_04090e03_080d0207_0c01060b;
    localparam logic [255:0] E_IN  = 256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
    localparam logic [255:0] E_OUT = 256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f;

    task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", name, obs, exp);
    endtask

    // Reference permutation written straight from the row-offset definition.
    function automatic logic [255:0] model(input logic [255:0] s, input int nb, input logic inv);
        logic [255:0] o;
        int off, src;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < nb; c++) begin
                off = (nb == 8 && r >= 2) ? r + 1 : r;
                src = inv ? (c - off + nb) % nb : (c + off) % nb;
                o[32*(nb-c)-8-8*r +: 8] = s[32*(nb-src)-8-8*r +: 8];
            end
        end
        return o;
    endfunction

    logic [191:0] q_dat[$];
    logic [191:0] q_orig[$];
    logic         q_inv[$];
    logic [3:0]   q_tag[$];

    initial begin
        logic [191:0] e_dat, e_orig;
        logic         e_inv, acc;
        logic [3:0]   e_tag;
        int           sent, got, cyc;

        rst_n = 1'b0;
        in_valid4 = 0; in_data4 = '0; in_inv4 = 0; in_tag4 = '0; out_ready4 = 1;
        in_valid6 = 0; in_data6 = 'x; in_inv6 = 0; in_tag6 = '0; out_ready6 = 1;
        in_valid8 = 0; in_data8 = '0; in_inv8 = 0; in_tag8 = '0; out_ready8 = 1;
        #12 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_out_valid", out_valid4, 0);
        chk("rst_out_data", out_data4, 0);
        chk("rst_out_tag", out_tag4, 0);
        chk("rst_out_inv", out_inv4, 0);
        chk("rst_in_ready", in_ready4, 1);

        // NB=4 forward, 2-cycle latency
        in_valid4 = 1; in_data4 = A_IN; in_inv4 = 0; in_tag4 = 4'd5;
        @(posedge clk); @(negedge clk);
        in_valid4 = 0;
        chk("fwd_not_early", out_valid4, 0);
        @(posedge clk); @(negedge clk);
        chk("fwd_valid", out_valid4, 1);
        chk("fwd_data", out_data4, A_OUT);
        chk("fwd_tag", out_tag4, 4'd5);
        chk("fwd_inv", out_inv4, 0);

        // NB=4 inverse
        in_valid4 = 1; in_data4 = A_OUT; in_inv4 = 1; in_tag4 = 4'd6;
        @(posedge clk); @(negedge clk);
        in_valid4 = 0;
        @(posedge clk); @(negedge clk);
        chk("inv_valid", out_valid4, 1);
        chk("inv_data", out_data4, A_IN);
        chk("inv_tag", out_tag4, 4'd6);
        chk("inv_inv", out_inv4, 1);

        // Back-to-back forward / inverse / forward
        in_valid4 = 1; in_data4 = A_IN; in_inv4 = 0; in_tag4 = 4'd1;
        @(posedge clk); @(negedge clk);
        in_data4 = A_OUT; in_inv4 = 1; in_tag4 = 4'd2;
        @(posedge clk); @(negedge clk);
        in_data4 = C_IN; in_inv4 = 0; in_tag4 = 4'd3;
        chk("b2b_1_data", out_data4, A_OUT);
        chk("b2b_1_tag", out_tag4, 4'd1);
        @(posedge clk); @(negedge clk);
        in_valid4 = 0;
        chk("b2b_2_data", out_data4, A_IN);
        chk("b2b_2_inv", out_inv4, 1);
        chk("b2b_2_tag", out_tag4, 4'd2);
        @(posedge clk); @(negedge clk);
        chk("b2b_3_valid", out_valid4, 1);
        chk("b2b_3_data", out_data4, C_OUT);
        chk("b2b_3_tag", out_tag4, 4'd3);
        @(posedge clk); @(negedge clk);
        chk("b2b_drained", out_valid4, 0);

        // NB=8 forward with offsets 0,1,3,4, then back through the inverse
        in_valid8 = 1; in_data8 = E_IN; in_inv8 = 0; in_tag8 = 4'hA;
        @(posedge clk); @(negedge clk);
        in_data8 = E_OUT; in_inv8 = 1; in_tag8 = 4'hB;
        @(posedge clk); @(negedge clk);
        in_valid8 = 0;
        chk("nb8_col0", out_data8[255 -: 32], 32'h00050e13);
        chk("nb8_col7", out_data8[31:0], 32'h1c010a0f);
        chk("nb8_fwd_data", out_data8, E_OUT);
        chk("nb8_fwd_tag", out_tag8, 4'hA);
        @(posedge clk); @(negedge clk);
        chk("nb8_inv_data", out_data8, E_IN);
        chk("nb8_inv_tag", out_tag8, 4'hB);

        // Backpressure: two beats fit, the third waits
        out_ready4 = 0;
        in_valid4 = 1; in_data4 = A_IN; in_inv4 = 0; in_tag4 = 4'd1;
        #1 chk("bp_rdy_1", in_ready4, 1);
        @(posedge clk); @(negedge clk);
        in_data4 = C_IN; in_inv4 = 0; in_tag4 = 4'd2;
        #1 chk("bp_rdy_2", in_ready4, 1);
        @(posedge clk); @(negedge clk);
        in_data4 = A_OUT; in_inv4 = 1; in_tag4 = 4'd3;
        #1 chk("bp_rdy_3_blocked", in_ready4, 0);
        chk("bp_hold_valid", out_valid4, 1);
        chk("bp_hold_tag", out_tag4, 4'd1);
        @(posedge clk); @(negedge clk);
        chk("bp_still_blocked", in_ready4, 0);
        chk("bp_stable_data", out_data4, A_OUT);
        chk("bp_stable_tag", out_tag4, 4'd1);
        chk("bp_stable_inv", out_inv4, 0);
        out_ready4 = 1;
        #1 chk("bp_rdy_comb", in_ready4, 1);
        @(posedge clk); @(negedge clk);
        in_valid4 = 0;
        chk("bp_out2_tag", out_tag4, 4'd2);
        chk("bp_out2_data", out_data4, C_OUT);
        @(posedge clk); @(negedge clk);
        chk("bp_out3_tag", out_tag4, 4'd3);
        chk("bp_out3_data", out_data4, A_IN);
        @(posedge clk); @(negedge clk);
        chk("bp_drained", out_valid4, 0);

        // Asynchronous reset with two beats in flight
        out_ready4 = 0;
        in_valid4 = 1; in_data4 = A_IN; in_inv4 = 0; in_tag4 = 4'd7;
        @(posedge clk); @(negedge clk);
        in_data4 = C_IN; in_tag4 = 4'd8;
        @(posedge clk); @(negedge clk);
        in_valid4 = 0;
        #1 chk("rst_mid_full", out_valid4, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", out_valid4, 0);
        chk("rst_mid_data", out_data4, 0);
        chk("rst_mid_tag", out_tag4, 0);
        chk("rst_mid_in_ready", in_ready4, 1);
        #1 rst_n = 1'b1;
        @(negedge clk);
        out_ready4 = 1;
        chk("rst_no_stale", out_valid4, 0);
        in_valid4 = 1; in_data4 = A_IN; in_inv4 = 0; in_tag4 = 4'd9;
        @(posedge clk); @(negedge clk);
        in_valid4 = 0;
        chk("rst_lat_not_early", out_valid4, 0);
        @(posedge clk); @(negedge clk);
        chk("rst_lat_valid", out_valid4, 1);
        chk("rst_lat_tag", out_tag4, 4'd9);
        chk("rst_lat_data", out_data4, A_OUT);
        @(posedge clk); @(negedge clk);
        chk("rst_after_empty", out_valid4, 0);

        // NB=6 random stream with random backpressure against a reference queue
        sent = 0; got = 0; cyc = 0; acc = 0;
        while (got < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (acc) begin
                in_valid6 = 0;
                in_data6  = 'x;
                acc = 0;
            end
            out_ready6 = ($urandom_range(0, 3) != 0);
            if (!in_valid6 && sent < 1000 && $urandom_range(0, 3) != 0) begin
                in_data6  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                in_inv6   = 1'($urandom_range(0, 1));
                in_tag6   = 4'(sent);
                in_valid6 = 1;
            end
            #1;
            if (out_valid6 && out_ready6) begin
                if (q_dat.size() == 0) begin
                    chk("s6_extra_beat", 256'(q_dat.size()), 1);
                end else begin
                    e_dat  = q_dat.pop_front();
                    e_orig = q_orig.pop_front();
                    e_inv  = q_inv.pop_front();
                    e_tag  = q_tag.pop_front();
                    chk("s6_data", out_data6, e_dat);
                    chk("s6_tag", out_tag6, e_tag);
                    chk("s6_inv", out_inv6, e_inv);
                    if (!e_inv) begin
                        chk("s6_roundtrip", model(256'(out_data6), 6, 1'b1), e_orig);
                    end
                end
                got++;
            end
            if (in_valid6 && in_ready6) begin
                q_dat.push_back(model(256'(in_data6), 6, in_inv6)[191:0]);
                q_orig.push_back(in_data6);
                q_inv.push_back(in_inv6);
                q_tag.push_back(in_tag6);
                sent++;
                acc = 1;
            end
        end
        @(negedge clk);
        in_valid6 = 0;
        chk("s6_beats_out", 256'(got), 1000);
        chk("s6_queue_empty", 256'(q_dat.size()), 0);
        chk("s6_idle_valid", out_valid6, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
